branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- EX-stage branch resolver. It is the "resolve" end of the fetch-side predict/flush protocol.
- Evaluates the B-type condition for the instruction in ID/EX and compares it with the prediction carried down the pipe.
- Registers the outcome into EX/MEM and drives the resolved-taken, flush and redirect signals back to fetch and the predictor.
- Also keeps synchronous branch and mispredict statistics.

Parameters:
- XLEN, 32, datapath width of operands, PC and immediate.
- CNT_W, 16, width of the statistics counters.
- SHADOW_CYCLES, 2, number of wrong-path cycles ignored after a flush (range 1..3).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- stall  in  1  pipeline hold; the EX/MEM register loads a bubble
- ex_valid  in  1  ID/EX slot holds a real instruction
- ex_op  in  7  opcode of the ID/EX instruction
- ex_funct3  in  3  branch compare type
- ex_rs1  in  XLEN  forwarded operand 1
- ex_rs2  in  XLEN  forwarded operand 2
- ex_pc  in  XLEN  PC of the branch itself
- ex_imm  in  XLEN  sign-extended B-immediate (bit 0 = 0)
- ex_pred_taken  in  1  prediction made at fetch for this instruction
- exmem_op  out  7  opcode in EX/MEM; predictor update qualifier
- exmem_taken  out  1  resolved direction in EX/MEM
- flush  out  1  one-cycle mispredict pulse
- redirect_pc  out  XLEN  correct next PC, valid when flush=1
- total_branches  out  CNT_W  resolved branch count
- mispredicts  out  CNT_W  flush count

Behaviour:
- **Reset.** Synchronous, active-high, and rst has priority over every other input. Reset values:
  - exmem_op=0, exmem_taken=0, flush=0, redirect_pc=0
  - counters=0
  - FSM=NORMAL, shadow count=0
- **Branch qualifier.** is_br = ex_valid & (ex_op==7'b1100011) & FSM==NORMAL.
- **Condition (combinational in EX), by funct3:**
  - 000 BEQ (rs1==rs2)
  - 001 BNE (rs1!=rs2)
  - 100 BLT (signed rs1<rs2)
  - 101 BGE (signed rs1>=rs2)
  - 110 BLTU (unsigned rs1<rs2)
  - 111 BGEU (unsigned rs1>=rs2)
  - 010 and 011 are illegal: treated as not-taken and do not count as branches.
- **Targets.** Computed modulo 2^XLEN, wrap-around allowed and not flagged:
  - target = ex_pc + ex_imm
  - fallthru = ex_pc + 4
- **Latency.** One cycle. Values sampled at edge N are visible on the outputs after edge N.
- **EX/MEM load (stall=0):**
  - exmem_op = is_br ? ex_op : 0
  - exmem_taken = is_br & cond
  - flush = is_br & (cond ^ ex_pred_taken)
  - redirect_pc = cond ? target : fallthru
- **stall=1.** The register loads a bubble: exmem_op=0, exmem_taken=0, flush=0, redirect_pc held. Upstream keeps the instruction, so it is resolved on the first cycle stall=0.
- **Flush shape.** flush is never high two consecutive cycles.
- **FSM:**
  - NORMAL → SHADOW when flush is loaded high; the shadow count loads SHADOW_CYCLES.
  - In SHADOW, ex_valid is ignored: the wrong-path instructions are bubbles, produce no flush and are not counted.
  - The count decrements every cycle, including during stall.
  - SHADOW → NORMAL on the cycle the count reaches 1→0.
- **Mispredict inside the shadow.** Impossible by construction, because is_br is gated by NORMAL.
- **Reset mid-shadow.** Returns to NORMAL immediately.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- **Defined:**
  - total_branches increments on every cycle exmem_op==B-type is loaded.
  - mispredicts increments on every cycle flush is loaded high.
  - Both saturate at all-ones (no wrap).
  - Both update in the same cycle as the EX/MEM load.
- **Undefined:** both outputs are tied to 0 and no counter flops are synthesised.

Decomposition:
- **Shared package `rv_pipe_pkg`:**
  - opcode constant OP_BRANCH=7'b1100011
  - funct3 constants F3_BEQ..F3_BGEU
  - FSM state enum {NORMAL, SHADOW}
- **Sub-module `branch_cmp`:** one natural combinational sub-module. Inputs funct3, rs1, rs2; outputs cond and illegal.
- **Top:** registers, FSM and counters.

Test Plan:
- **BEQ correctly predicted.** rs1=rs2=5, pred_taken=1, pc=0x100, imm=0x20 → next cycle exmem_taken=1, flush=0, total_branches=1, mispredicts=0.
- **BLT mispredict.** BLT signed, rs1=0xFFFFFFFF, rs2=1, pred_taken=0, pc=0x200, imm=-8 → flush=1 for exactly one cycle, redirect_pc=0x1F8, mispredicts=1.
- **Wrong-path suppression.** BNE mispredict with SHADOW_CYCLES=2, then two back-to-back B-type instructions with wrong predictions → only one flush, counters +1/+1. A branch in the third cycle after the flush is resolved normally.
- **BLTU vs BLT on the same operands.** rs1=0x80000000, rs2=1: BLTU → taken=0; BLT → taken=1. funct3=010 → taken=0, not counted.
- **Stall.** stall=1 for 3 cycles with a mispredicting branch held at the inputs → no flush while stalled; a single flush the cycle after stall drops.
- **Reset and saturation.**
  - Assert rst during SHADOW with flush pending → all outputs 0 and FSM=NORMAL after the edge.
  - With BRU_PERF_CNT_EN, preload 0xFFFF branches → count stays 0xFFFF.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: the branch opcode, the B-type compare encodings
// and the state type of the branch-resolve shadow FSM.
package rv_pipe_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        SHADOW = 1'b1
    } bru_state_e;

endpackage

// File: rtl/branch_cmp.sv
// B-type condition evaluator. Purely combinational; funct3 010/011 are
// reported as illegal and evaluate not-taken.
module branch_cmp
    import rv_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            cond,
    output logic            illegal
);

    // Select the compare for this funct3; unknown encodings are illegal and not-taken
    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (rs1 == rs2);
            F3_BNE:  cond = (rs1 != rs2);
            F3_BLT:  cond = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: cond = (rs1 <  rs2);
            F3_BGEU: cond = (rs1 >= rs2);
            default: begin
                cond    = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: evaluates the branch condition, compares it with
// the fetch-time prediction and registers taken/flush/redirect into EX/MEM.
// After a flush a short SHADOW window ignores the wrong-path instructions.
// Optional statistics counters are built only when BRU_PERF_CNT_EN is defined;
// otherwise total_branches and mispredicts are constant zero.
module branch_resolve_unit
    import rv_pipe_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int CNT_W         = 16,
    parameter int SHADOW_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic [6:0]       ex_op,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    output logic [6:0]       exmem_op,
    output logic             exmem_taken,
    output logic             flush,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] total_branches,
    output logic [CNT_W-1:0] mispredicts
);

    // Shadow length fits in two bits (1..3 wrong-path cycles)
    localparam logic [1:0] SHADOW_INIT = SHADOW_CYCLES[1:0];

    logic            cond_s;
    logic            illegal_s;
    logic            in_normal_s;
    logic            br_valid_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] fallthru_s;

    logic [6:0]      exmem_op_d,    exmem_op_q;
    logic            exmem_taken_d, exmem_taken_q;
    logic            flush_d,       flush_q;
    logic [XLEN-1:0] redirect_pc_d, redirect_pc_q;
    bru_state_e      state_d,       state_q;
    logic [1:0]      shadow_cnt_d,  shadow_cnt_q;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .funct3  (ex_funct3),
        .rs1     (ex_rs1),
        .rs2     (ex_rs2),
        .cond    (cond_s),
        .illegal (illegal_s)
    );

    // Candidate next PCs, both wrapping modulo 2^XLEN
    always_comb begin
        target_s   = ex_pc + ex_imm;
        fallthru_s = ex_pc + XLEN'(4);
    end

    // FSM output decode: branches are only resolved outside the shadow window
    always_comb begin
        in_normal_s = 1'b0;
        case (state_q)
            NORMAL:  in_normal_s = 1'b1;
            SHADOW:  in_normal_s = 1'b0;
            default: in_normal_s = 1'b0;
        endcase
    end

    // A real, legal branch seen while NORMAL; illegal compares are not branches
    always_comb begin
        br_valid_s = ex_valid & (ex_op == OP_BRANCH) & in_normal_s & ~illegal_s;
    end

    // EX/MEM next value: stall inserts a bubble and keeps the last redirect target
    always_comb begin
        exmem_op_d    = 7'd0;
        exmem_taken_d = 1'b0;
        flush_d       = 1'b0;
        redirect_pc_d = redirect_pc_q;
        if (stall) begin
            redirect_pc_d = redirect_pc_q;
        end else begin
            exmem_op_d    = br_valid_s ? ex_op : 7'd0;
            exmem_taken_d = br_valid_s & cond_s;
            flush_d       = br_valid_s & (cond_s ^ ex_pred_taken);
            redirect_pc_d = cond_s ? target_s : fallthru_s;
        end
    end

    // Shadow FSM next state: enter on a loaded flush, count down every cycle
    always_comb begin
        state_d      = state_q;
        shadow_cnt_d = shadow_cnt_q;
        case (state_q)
            NORMAL: begin
                if (flush_d) begin
                    state_d      = SHADOW;
                    shadow_cnt_d = SHADOW_INIT;
                end else begin
                    state_d      = NORMAL;
                    shadow_cnt_d = 2'd0;
                end
            end
            SHADOW: begin
                if (shadow_cnt_q <= 2'd1) begin
                    state_d      = NORMAL;
                    shadow_cnt_d = 2'd0;
                end else begin
                    state_d      = SHADOW;
                    shadow_cnt_d = shadow_cnt_q - 2'd1;
                end
            end
            default: begin
                state_d      = NORMAL;
                shadow_cnt_d = 2'd0;
            end
        endcase
    end

    // EX/MEM and FSM state registers; reset wins over stall and everything else
    always_ff @(posedge clk) begin
        if (rst) begin
            exmem_op_q    <= 7'd0;
            exmem_taken_q <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= {XLEN{1'b0}};
            state_q       <= NORMAL;
            shadow_cnt_q  <= 2'd0;
        end else begin
            exmem_op_q    <= exmem_op_d;
            exmem_taken_q <= exmem_taken_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            state_q       <= state_d;
            shadow_cnt_q  <= shadow_cnt_d;
        end
    end

    assign exmem_op    = exmem_op_q;
    assign exmem_taken = exmem_taken_q;
    assign flush       = flush_q;
    assign redirect_pc = redirect_pc_q;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] total_branches_d, total_branches_q;
    logic [CNT_W-1:0] mispredicts_d,    mispredicts_q;

    // Saturating statistics, updated alongside the EX/MEM load
    always_comb begin
        total_branches_d = total_branches_q;
        mispredicts_d    = mispredicts_q;
        if ((exmem_op_d == OP_BRANCH) && (total_branches_q != {CNT_W{1'b1}})) begin
            total_branches_d = total_branches_q + CNT_W'(1);
        end else begin
            total_branches_d = total_branches_q;
        end
        if (flush_d && (mispredicts_q != {CNT_W{1'b1}})) begin
            mispredicts_d = mispredicts_q + CNT_W'(1);
        end else begin
            mispredicts_d = mispredicts_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            total_branches_q <= {CNT_W{1'b0}};
            mispredicts_q    <= {CNT_W{1'b0}};
        end else begin
            total_branches_q <= total_branches_d;
            mispredicts_q    <= mispredicts_d;
        end
    end

    assign total_branches = total_branches_q;
    assign mispredicts    = mispredicts_q;
`else
    assign total_branches = {CNT_W{1'b0}};
    assign mispredicts    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (default parameters).
// Counter expectations collapse to zero when BRU_PERF_CNT_EN is not defined.
module tb_branch_resolve_unit;

`ifdef BRU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] OPB = 7'b1100011;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [6:0]  ex_op;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rs1;
    logic [31:0] ex_rs2;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic        ex_pred_taken;
    logic [6:0]  exmem_op;
    logic        exmem_taken;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [15:0] total_branches;
    logic [15:0] mispredicts;

    int n_checks = 0;
    int n_errors = 0;

    branch_resolve_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_op          (ex_op),
        .ex_funct3      (ex_funct3),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_pred_taken  (ex_pred_taken),
        .exmem_op       (exmem_op),
        .exmem_taken    (exmem_taken),
        .flush          (flush),
        .redirect_pc    (redirect_pc),
        .total_branches (total_branches),
        .mispredicts    (mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Expected counter value, zero when the counters are compiled out
    function automatic logic [31:0] ec(input int v);
        return PERF ? 32'(v) : 32'h0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] imm, input logic pred);
        ex_valid      = 1'b1;
        ex_op         = OPB;
        ex_funct3     = f3;
        ex_rs1        = a;
        ex_rs2        = b;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_pred_taken = pred;
    endtask

    task automatic idle();
        ex_valid = 1'b0;
        ex_op    = 7'd0;
    endtask

    task automatic check_out(input string tag, input logic [6:0] op, input logic tk, input logic fl);
        check_eq({tag, ".op"},    32'(exmem_op),    32'(op));
        check_eq({tag, ".taken"}, 32'(exmem_taken), 32'(tk));
        check_eq({tag, ".flush"}, 32'(flush),       32'(fl));
    endtask

    task automatic check_cnt(input string tag, input int br, input int mp);
        check_eq({tag, ".total"}, 32'(total_branches), ec(br));
        check_eq({tag, ".misp"},  32'(mispredicts),    ec(mp));
    endtask

    initial begin
        // Reset with a mispredicting branch at the inputs: reset must win
        rst = 1'b1;
        stall = 1'b0;
        drive_br(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        step();
        step();
        check_out("reset", 7'd0, 1'b0, 1'b0);
        check_eq("reset.redirect", redirect_pc, 32'h0);
        check_cnt("reset", 0, 0);
        rst = 1'b0;

        // BEQ correctly predicted taken
        drive_br(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1);
        step();
        check_out("beq", OPB, 1'b1, 1'b0);
        check_eq("beq.redirect", redirect_pc, 32'h120);
        check_cnt("beq", 1, 0);
        idle();
        step();
        check_out("beq_idle", 7'd0, 1'b0, 1'b0);

        // BLT signed mispredict: -1 < 1, target wraps backwards
        drive_br(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'hFFFF_FFF8, 1'b0);
        step();
        check_out("blt_mp", OPB, 1'b1, 1'b1);
        check_eq("blt_mp.redirect", redirect_pc, 32'h1F8);
        check_cnt("blt_mp", 2, 1);
        idle();
        step();
        check_eq("blt_mp.pulse", 32'(flush), 32'h0);
        step();

        // BNE mispredict followed by two wrong-path mispredicting branches
        drive_br(3'b001, 32'd1, 32'd2, 32'h300, 32'h40, 1'b0);
        step();
        check_out("bne_mp", OPB, 1'b1, 1'b1);
        check_eq("bne_mp.redirect", redirect_pc, 32'h340);
        drive_br(3'b000, 32'd7, 32'd7, 32'h304, 32'h8, 1'b0);
        step();
        check_out("shadow1", 7'd0, 1'b0, 1'b0);
        drive_br(3'b001, 32'd1, 32'd1, 32'h308, 32'h8, 1'b1);
        step();
        check_out("shadow2", 7'd0, 1'b0, 1'b0);
        check_cnt("shadow2", 3, 2);
        drive_br(3'b000, 32'd9, 32'd9, 32'h400, 32'h8, 1'b0);
        step();
        check_out("post_shadow", OPB, 1'b1, 1'b1);
        check_eq("post_shadow.redirect", redirect_pc, 32'h408);
        check_cnt("post_shadow", 4, 3);
        idle();
        step();
        step();

        // Same operands, unsigned vs signed, then an illegal funct3
        drive_br(3'b110, 32'h8000_0000, 32'd1, 32'h500, 32'h10, 1'b0);
        step();
        check_out("bltu", OPB, 1'b0, 1'b0);
        check_eq("bltu.redirect", redirect_pc, 32'h504);
        drive_br(3'b100, 32'h8000_0000, 32'd1, 32'h600, 32'h10, 1'b1);
        step();
        check_out("blt", OPB, 1'b1, 1'b0);
        check_eq("blt.redirect", redirect_pc, 32'h610);
        drive_br(3'b010, 32'h8000_0000, 32'd1, 32'h700, 32'h10, 1'b0);
        step();
        check_out("illegal", 7'd0, 1'b0, 1'b0);
        check_eq("illegal.redirect", redirect_pc, 32'h704);
        check_cnt("illegal", 6, 3);

        // Mispredicting BGE held through a 3-cycle stall
        drive_br(3'b101, 32'd5, 32'd3, 32'h800, 32'h10, 1'b0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("stall", 7'd0, 1'b0, 1'b0);
            check_eq("stall.redirect", redirect_pc, 32'h704);
        end
        stall = 1'b0;
        step();
        check_out("unstall", OPB, 1'b1, 1'b1);
        check_eq("unstall.redirect", redirect_pc, 32'h810);
        check_cnt("unstall", 7, 4);
        step();
        check_eq("unstall.pulse", 32'(flush), 32'h0);
        idle();
        step();

        // Reset while a flush is pending and the shadow is armed
        drive_br(3'b111, 32'd1, 32'd2, 32'h900, 32'h10, 1'b1);
        step();
        check_out("bgeu_mp", OPB, 1'b0, 1'b1);
        check_eq("bgeu_mp.redirect", redirect_pc, 32'h904);
        rst = 1'b1;
        step();
        check_out("rst_shadow", 7'd0, 1'b0, 1'b0);
        check_eq("rst_shadow.redirect", redirect_pc, 32'h0);
        check_cnt("rst_shadow", 0, 0);
        rst = 1'b0;
        step();
        check_out("after_rst", OPB, 1'b0, 1'b1);
        check_cnt("after_rst", 1, 1);
        idle();
        step();
        step();

`ifdef BRU_PERF_CNT_EN
        // Saturation: preload all-ones, then a mispredicting branch
        force dut.total_branches_q = 16'hFFFF;
        force dut.mispredicts_q    = 16'hFFFF;
        #1;
        release dut.total_branches_q;
        release dut.mispredicts_q;
        drive_br(3'b000, 32'd3, 32'd3, 32'hA00, 32'h10, 1'b0);
        step();
        check_eq("sat.flush", 32'(flush), 32'h1);
        check_eq("sat.total", 32'(total_branches), 32'h0000_FFFF);
        check_eq("sat.misp",  32'(mispredicts),    32'h0000_FFFF);
        idle();
        step();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
